ram8_arbiter: RTL
=================

RAM8_ARBITER -- requirements
Module: ram8_arbiter

Interface
REQ-001 The module SHALL have one parameter: WIDTH, default 16, data word width in bits.
REQ-002 The module SHALL have one clock; reset is synchronous and active-high, with ports named clk and reset.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req0 / req1  input  1  access request from requester 0 / 1.
REQ-006 we0 / we1  input  1  1 = write, 0 = read, for requester 0 / 1.
REQ-007 addr0 / addr1  input  3  word address for requester 0 / 1.
REQ-008 din0 / din1  input  WIDTH  write data for requester 0 / 1.
REQ-009 gnt0 / gnt1  output  1  requester 0 / 1 owns the RAM for the current transaction.
REQ-010 ack0 / ack1  output  1  one-cycle completion pulse to requester 0 / 1.
REQ-011 rdata  output  WIDTH  data returned with ack; valid only while ack0 or ack1 is high.
REQ-012 ram_addr  output  3  address to the shared 8-word RAM.
REQ-013 ram_din  output  WIDTH  write data to the RAM.
REQ-014 ram_load  output  8  one-hot per-word load enables, bit i = word i, equivalent to an 8-way demux of the load strobe by ram_addr.
REQ-015 ram_dout  input  WIDTH  combinational read data from the RAM at ram_addr.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCESS, ACK; each transaction takes exactly 3 cycles, IDLE->ACCESS->ACK->IDLE.
REQ-017 In IDLE, req0/req1 are sampled; with no request the FSM stays in IDLE.
REQ-018 With exactly one request in IDLE, that requester SHALL win.
REQ-019 With both requests in IDLE, the winner is the requester not served last (round-robin pointer "last").
REQ-020 On a win, the winner's we/addr/din SHALL be registered, its gnt set, "last" updated to the winner, and the FSM moves to ACCESS.
REQ-021 gntN SHALL be high during ACCESS and ACK of requester N's transaction only; gnt0 and gnt1 are never both high.
REQ-022 ram_addr and ram_din SHALL be driven from the registered transaction during ACCESS and ACK, and hold their last values otherwise.
REQ-023 ram_load SHALL be all-zero except in ACCESS with registered we=1: exactly bit ram_addr high for that one cycle.
REQ-024 rdata SHALL be loaded at the ACCESS->ACK edge: ram_dout for reads, the registered din for writes.
REQ-025 ackN SHALL be high for exactly the ACK cycle of requester N's transaction.
REQ-026 reqN SHALL be ignored outside IDLE; deasserting req mid-transaction does not abort it, and the ack still issues.
REQ-027 A requester holding req high through its ack is re-arbitrated in the following IDLE cycle like a new request.
REQ-028 Read-after-write of the same address by any requester SHALL return the written data; the write is committed at the ACCESS->ACK edge.

Reset
REQ-029 With reset high at a rising edge, the FSM SHALL go to IDLE regardless of state.
REQ-030 The same reset edge SHALL clear gnt0, gnt1, ack0, ack1, rdata, ram_addr, and ram_din to 0, and set "last" to 1 so requester 0 wins the first tie.
REQ-031 ram_load SHALL be forced to all-zero combinationally while reset is high, so a reset asserted during ACCESS produces no RAM write.
REQ-032 An in-flight transaction aborted by reset SHALL produce no ack; requesters must re-request.

Verification
REQ-033 Reset release, then req0=1, we0=1, addr0=5, din0=16'hBEEF -> gnt0 high in cycles 1-2, ram_load=8'b0010_0000 in cycle 1 only, ack0 in cycle 2, word 5 = BEEF.
REQ-034 After REQ-033, req1=1, we1=0, addr1=5 -> ack1 with rdata=16'hBEEF, ram_load stays 0.
REQ-035 req0 and req1 both held high from reset release -> grants alternate 0,1,0,1; every 3rd cycle one ack; never both gnt high.
REQ-036 Write to addr 7 with reset asserted in its ACCESS cycle -> ram_load=0 at that edge, word 7 unchanged, no ack, all outputs 0 next cycle.
REQ-037 Write all 8 addresses with value=addr*3, then read back each -> rdata matches for every addr 0..7; each write asserts exactly one ram_load bit.
REQ-038 req0 pulsed for 1 cycle in IDLE, then dropped -> transaction completes, ack0 asserted once, FSM returns to IDLE and stays idle.

Source files
------------

// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter in front of a shared 8-word RAM.
// Every transaction is a fixed IDLE -> ACCESS -> ACK sequence.
module ram8_arbiter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [2:0]       addr0,
  input  logic [2:0]       addr1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       ram_addr,
  output logic [WIDTH-1:0] ram_din,
  output logic [7:0]       ram_load,
  input  logic [WIDTH-1:0] ram_dout
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] ACK    = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             last_q, last_d;
  logic             we_q, we_d;
  logic [2:0]       addr_q, addr_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             pick1;

  // Requester 1 wins when alone, or on a tie when 0 was served last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    din_d   = din_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    ack0_d  = ack0_q;
    ack1_d  = ack1_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req0 | req1) begin
          state_d = ACCESS;
          last_d  = pick1;
          gnt0_d  = ~pick1;
          gnt1_d  = pick1;
          we_d    = pick1 ? we1 : we0;
          addr_d  = pick1 ? addr1 : addr0;
          din_d   = pick1 ? din1 : din0;
        end
      end
      ACCESS: begin
        state_d = ACK;
        rdata_d = we_q ? din_q : ram_dout;
        ack0_d  = gnt0_q;
        ack1_d  = gnt1_q;
      end
      ACK: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      rdata_q <= rdata_d;
    end
  end

  // Reset gates the strobe so an aborted ACCESS never writes.
  assign ram_load = (state_q == ACCESS && we_q && !reset)
                  ? (8'd1 << addr_q) : 8'd0;

  assign gnt0     = gnt0_q;
  assign gnt1     = gnt1_q;
  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rdata    = rdata_q;
  assign ram_addr = addr_q;
  assign ram_din  = din_q;

endmodule
